// File: rtl/adc_sched_pkg.sv
// Shared types and default widths for the ADC sample scheduler.
package adc_sched_pkg;

    localparam int DATA_W = 12;
    localparam int CH_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/adc_tick_gen.sv
// Sample-rate divider: one-cycle tick every SAMPLE_DIV clocks while enabled.
module adc_tick_gen #(
    parameter int unsigned SAMPLE_DIV = 6250
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == CNT_LAST);

    always_comb begin
        if (!enable_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sample_sched.sv
// Periodic ADC sample scheduler: issues one sequencer command per tick and
// captures the matching response, with timeout and dropped-tick accounting.
module adc_sample_sched #(
    parameter int unsigned SAMPLE_DIV  = 6250,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int          DATA_W      = adc_sched_pkg::DATA_W,
    parameter int          CH_W        = adc_sched_pkg::CH_W
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic [CH_W-1:0]   channel_i,
    output logic              cmd_valid_o,
    output logic              cmd_sop_o,
    output logic              cmd_eop_o,
    output logic [CH_W-1:0]   cmd_channel_o,
    input  logic              cmd_ready_i,
    input  logic              rsp_valid_i,
    input  logic [CH_W-1:0]   rsp_channel_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    output logic              sample_valid_o,
    output logic [DATA_W-1:0] sample_data_o,
    output logic [CH_W-1:0]   sample_channel_o,
    output logic              timeout_o,
    output logic              busy_o,
    output logic [15:0]       overrun_cnt_o
);

    import adc_sched_pkg::state_e;
    import adc_sched_pkg::IDLE;
    import adc_sched_pkg::ISSUE;
    import adc_sched_pkg::WAIT;

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [15:0]       ovr_q, ovr_d;
    logic              smp_valid_q, smp_valid_d;
    logic [DATA_W-1:0] smp_data_q, smp_data_d;
    logic [CH_W-1:0]   smp_ch_q, smp_ch_d;
    logic              timeout_q, timeout_d;
    logic              tick;
    logic              expired;
    logic              rsp_match;

    adc_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

    assign expired   = (tmo_q == TMO_LAST);
    assign rsp_match = rsp_valid_i && (rsp_channel_i == ch_q);

    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        tmo_d       = tmo_q;
        ovr_d       = ovr_q;
        smp_valid_d = 1'b0;
        smp_data_d  = smp_data_q;
        smp_ch_d    = smp_ch_q;
        timeout_d   = 1'b0;

        if (tick && (state_q != IDLE) && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ISSUE;
                    ch_d    = channel_i;
                    tmo_d   = '0;
                end
            end
            ISSUE: begin
                tmo_d = tmo_q + 1'b1;
                if (expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else if (cmd_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // A matching response beats a simultaneous timeout.
                if (rsp_match) begin
                    state_d     = IDLE;
                    smp_valid_d = 1'b1;
                    smp_data_d  = rsp_data_i;
                    smp_ch_d    = rsp_channel_i;
                end else if (expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            tmo_q       <= '0;
            ovr_q       <= '0;
            smp_valid_q <= 1'b0;
            smp_data_q  <= '0;
            smp_ch_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            tmo_q       <= tmo_d;
            ovr_q       <= ovr_d;
            smp_valid_q <= smp_valid_d;
            smp_data_q  <= smp_data_d;
            smp_ch_q    <= smp_ch_d;
            timeout_q   <= timeout_d;
        end
    end

    // Command strobes decode straight from state so reset clears them at once.
    assign cmd_valid_o      = (state_q == ISSUE);
    assign cmd_sop_o        = (state_q == ISSUE);
    assign cmd_eop_o        = (state_q == ISSUE);
    assign cmd_channel_o    = (state_q == ISSUE) ? ch_q : '0;
    assign busy_o           = (state_q != IDLE);
    assign sample_valid_o   = smp_valid_q;
    assign sample_data_o    = smp_data_q;
    assign sample_channel_o = smp_ch_q;
    assign timeout_o        = timeout_q;
    assign overrun_cnt_o    = ovr_q;

endmodule

// File: tb/tb_adc_sample_sched.sv
// Scoreboard bench for adc_sample_sched: main instance with a long timeout,
// second instance with TIMEOUT_CYC=16 for timeout and expiry-race cases.
module tb_adc_sample_sched;

    localparam int DW = 12;
    localparam int CW = 5;

    typedef struct {
        int            cyc;
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst_ni;
    logic          enable_i;
    logic [CW-1:0] channel_i;
    logic          cmd_ready_i;
    logic          rsp_valid_i;
    logic [CW-1:0] rsp_channel_i;
    logic [DW-1:0] rsp_data_i;
    logic          cmd_valid_o, cmd_sop_o, cmd_eop_o;
    logic [CW-1:0] cmd_channel_o;
    logic          sample_valid_o;
    logic [DW-1:0] sample_data_o;
    logic [CW-1:0] sample_channel_o;
    logic          timeout_o, busy_o;
    logic [15:0]   overrun_cnt_o;

    logic          en_to;
    logic [CW-1:0] channel_to;
    logic          ready_to;
    logic          rsp_valid_to;
    logic [CW-1:0] rsp_channel_to;
    logic [DW-1:0] rsp_data_to;
    logic          cmd_valid_to, cmd_sop_to, cmd_eop_to;
    logic [CW-1:0] cmd_channel_to;
    logic          sample_valid_to;
    logic [DW-1:0] sample_data_to;
    logic [CW-1:0] sample_channel_to;
    logic          timeout_to, busy_to;
    logic [15:0]   overrun_to;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   samples_seen = 0;
    exp_t sb_q[$];

    adc_sample_sched #(
        .SAMPLE_DIV (8), .TIMEOUT_CYC (64), .DATA_W (DW), .CH_W (CW)
    ) u_dut (
        .clk (clk), .rst_ni (rst_ni), .enable_i (enable_i), .channel_i (channel_i),
        .cmd_valid_o (cmd_valid_o), .cmd_sop_o (cmd_sop_o), .cmd_eop_o (cmd_eop_o),
        .cmd_channel_o (cmd_channel_o), .cmd_ready_i (cmd_ready_i),
        .rsp_valid_i (rsp_valid_i), .rsp_channel_i (rsp_channel_i), .rsp_data_i (rsp_data_i),
        .sample_valid_o (sample_valid_o), .sample_data_o (sample_data_o),
        .sample_channel_o (sample_channel_o), .timeout_o (timeout_o), .busy_o (busy_o),
        .overrun_cnt_o (overrun_cnt_o)
    );

    adc_sample_sched #(
        .SAMPLE_DIV (8), .TIMEOUT_CYC (16), .DATA_W (DW), .CH_W (CW)
    ) u_dut_to (
        .clk (clk), .rst_ni (rst_ni), .enable_i (en_to), .channel_i (channel_to),
        .cmd_valid_o (cmd_valid_to), .cmd_sop_o (cmd_sop_to), .cmd_eop_o (cmd_eop_to),
        .cmd_channel_o (cmd_channel_to), .cmd_ready_i (ready_to),
        .rsp_valid_i (rsp_valid_to), .rsp_channel_i (rsp_channel_to), .rsp_data_i (rsp_data_to),
        .sample_valid_o (sample_valid_to), .sample_data_o (sample_data_to),
        .sample_channel_o (sample_channel_to), .timeout_o (timeout_to), .busy_o (busy_to),
        .overrun_cnt_o (overrun_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string detail);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts negedges up to and including the first one with cmd_valid_o high.
    task automatic wait_cmd(input string name, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_valid_o && n < budget);
        if (!cmd_valid_o) fail(name, "no command within budget");
    endtask

    task automatic send_rsp(input logic [CW-1:0] ch, input logic [DW-1:0] data, input bit expect_sample);
        exp_t e;
        rsp_valid_i   = 1'b1;
        rsp_channel_i = ch;
        rsp_data_i    = data;
        if (expect_sample) begin
            e.cyc  = cyc + 1;
            e.ch   = ch;
            e.data = data;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard whenever the main instance presents a sample.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (cmd_valid_o && cmd_ready_i) hs_cnt++;
            if (timeout_o) check("main_timeout", {31'd0, timeout_o}, 32'd0);
            if (sample_valid_o) begin
                samples_seen++;
                if (sb_q.size() == 0) begin
                    fail("sample_unexpected", $sformatf("data 0x%0h ch %0d", sample_data_o, sample_channel_o));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sample_data", 32'(sample_data_o), 32'(e.data));
                    check("sample_channel", 32'(sample_channel_o), 32'(e.ch));
                    check("sample_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int to_cnt, to_n, busy25, sv_cnt, sv_n, cmd_cycles, quiet;
        logic [DW-1:0] sv_data;
        int cmd_ns[$];
        logic prev_cmd;

        rst_ni = 1'b0;
        enable_i = 1'b0; channel_i = '0; cmd_ready_i = 1'b1;
        rsp_valid_i = 1'b0; rsp_channel_i = '0; rsp_data_i = '0;
        en_to = 1'b0; channel_to = 5'd7; ready_to = 1'b1;
        rsp_valid_to = 1'b0; rsp_channel_to = 5'd7; rsp_data_to = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_cmd_valid", {31'd0, cmd_valid_o}, 32'd0);
        check("rst_cmd_channel", 32'(cmd_channel_o), 32'd0);
        check("rst_sample_valid", {31'd0, sample_valid_o}, 32'd0);
        check("rst_overrun", 32'(overrun_cnt_o), 32'd0);
        step();
        rst_ni = 1'b1;

        // Timeout instance: no response to the first command, racing response to the second.
        step();
        en_to = 1'b1;
        to_cnt = 0; to_n = 0; busy25 = 1; sv_cnt = 0; sv_n = 0; sv_data = '0;
        cmd_cycles = 0; prev_cmd = 1'b0;
        for (int k = 1; k <= 56; k++) begin
            @(negedge clk);
            if (timeout_to) begin
                to_cnt++;
                if (to_n == 0) to_n = k;
            end
            if (cmd_valid_to) cmd_cycles++;
            if (cmd_valid_to && !prev_cmd) cmd_ns.push_back(k);
            prev_cmd = cmd_valid_to;
            if (k == 25) busy25 = int'(busy_to);
            if (sample_valid_to) begin
                sv_cnt++; sv_n = k; sv_data = sample_data_to;
            end
            if (k == 42) en_to = 1'b0;
            if (k == 48) begin
                rsp_valid_to = 1'b1; rsp_data_to = 12'h3E1;
            end
            if (k == 49) rsp_valid_to = 1'b0;
        end
        check("to_pulse_count", to_cnt, 1);
        check("to_pulse_cycle", to_n, 25);
        check("to_idle_after", busy25, 0);
        check("to_cmd_cycles", cmd_cycles, 2);
        check("to_cmd_count", cmd_ns.size(), 2);
        if (cmd_ns.size() == 2) check("to_next_cmd_cycle", cmd_ns[1], 33);
        check("race_sample_count", sv_cnt, 1);
        check("race_sample_cycle", sv_n, 49);
        check("race_sample_data", 32'(sv_data), 32'h3E1);
        check("to_overrun", 32'(overrun_to), 32'd3);

        // Basic transaction: first command SAMPLE_DIV+1 negedges after enable.
        step();
        enable_i = 1'b1;
        wait_cmd("first_cmd", 20, n);
        check("first_cmd_latency", n, 9);
        check("cmd_sop", {31'd0, cmd_sop_o}, 32'd1);
        check("cmd_eop", {31'd0, cmd_eop_o}, 32'd1);
        check("cmd_channel_ch0", 32'(cmd_channel_o), 32'd0);
        @(negedge clk);
        check("cmd_single_cycle", {31'd0, cmd_valid_o}, 32'd0);
        step();
        step();
        send_rsp(5'd0, 12'hABC, 1'b1);
        step();
        rsp_valid_i = 1'b0; cmd_ready_i = 1'b0; channel_i = 5'd5;

        // Back-pressure: ready low 5 cycles, command held 6 cycles with changing channel_i.
        wait_cmd("stall_cmd", 20, n);
        check("stall_valid_0", {31'd0, cmd_valid_o}, 32'd1);
        check("stall_channel_0", 32'(cmd_channel_o), 32'd5);
        for (int i = 1; i <= 5; i++) begin
            step();
            channel_i = 5'd9;
            if (i == 5) cmd_ready_i = 1'b1;
            @(negedge clk);
            check($sformatf("stall_valid_%0d", i), {31'd0, cmd_valid_o}, 32'd1);
            check($sformatf("stall_channel_%0d", i), 32'(cmd_channel_o), 32'd5);
        end
        step();
        send_rsp(5'd5, 12'h5A5, 1'b1);
        channel_i = 5'd0;
        @(negedge clk);
        check("stall_valid_drop", {31'd0, cmd_valid_o}, 32'd0);
        step();
        rsp_valid_i = 1'b0;

        // Wrong-channel response ignored, then matching one; late response outside WAIT ignored.
        wait_cmd("filter_cmd", 20, n);
        step();
        send_rsp(5'd3, 12'h777, 1'b0);
        step();
        send_rsp(5'd0, 12'h123, 1'b1);
        step();
        send_rsp(5'd0, 12'hFFF, 1'b0);
        step();
        rsp_valid_i = 1'b0;
        @(negedge clk);
        check("hold_data", 32'(sample_data_o), 32'h123);
        check("hold_channel", 32'(sample_channel_o), 32'd0);
        check("idle_cmd_channel", 32'(cmd_channel_o), 32'd0);

        // Slow response: two ticks dropped while waiting.
        wait_cmd("slow_cmd", 20, n);
        repeat (20) step();
        send_rsp(5'd0, 12'h456, 1'b1);
        step();
        rsp_valid_i = 1'b0;
        @(negedge clk);
        check("overrun_two", 32'(overrun_cnt_o), 32'd2);

        // Reset during WAIT clears everything at once; the late response is ignored.
        wait_cmd("reset_cmd", 20, n);
        step();
        step();
        check("pre_reset_busy", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_cmd_valid", {31'd0, cmd_valid_o}, 32'd0);
        check("arst_sample_data", 32'(sample_data_o), 32'd0);
        check("arst_sample_channel", 32'(sample_channel_o), 32'd0);
        check("arst_overrun", 32'(overrun_cnt_o), 32'd0);
        check("arst_timeout", {31'd0, timeout_o}, 32'd0);
        step();
        rst_ni = 1'b1;
        enable_i = 1'b0;
        send_rsp(5'd0, 12'hDEF, 1'b0);
        step();
        rsp_valid_i = 1'b0;
        enable_i = 1'b1;
        wait_cmd("post_reset_cmd", 20, n);
        check("post_reset_latency", n, 9);

        // Enable dropped mid-transaction: it completes, then no further commands.
        step();
        enable_i = 1'b0;
        step();
        step();
        send_rsp(5'd0, 12'h2B7, 1'b1);
        step();
        rsp_valid_i = 1'b0;
        quiet = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (cmd_valid_o) quiet++;
        end
        check("disabled_no_cmd", quiet, 0);
        check("final_busy", {31'd0, busy_o}, 32'd0);
        check("final_cmd_channel", 32'(cmd_channel_o), 32'd0);
        check("handshake_count", hs_cnt, 6);
        check("samples_seen", samples_seen, 5);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sample_sched.md
ADC_SAMPLE_SCHED -- requirements
Module: adc_sample_sched

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 6250: clk cycles per sample tick (8 kHz at 50 MHz), legal range 4..65535.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: max cycles from command issue to response.
REQ-003 SHALL have parameter DATA_W, default 12: ADC sample width.
REQ-004 SHALL have parameter CH_W, default 5: ADC channel field width.
REQ-005 SHALL have port clk  in  1: sole clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_ni  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port enable_i  in  1: sampling enable.
REQ-008 SHALL have port channel_i  in  CH_W: channel to sample, latched at each accepted tick.
REQ-009 SHALL have ports cmd_valid_o, cmd_sop_o, cmd_eop_o  out  1 each: ADC sequencer command strobes.
REQ-010 SHALL have port cmd_channel_o  out  CH_W: command channel.
REQ-011 SHALL have port cmd_ready_i  in  1: ADC accepts the command.
REQ-012 SHALL have ports rsp_valid_i  in  1, rsp_channel_i  in  CH_W, rsp_data_i  in  DATA_W: ADC response.
REQ-013 SHALL have ports sample_valid_o  out  1, sample_data_o  out  DATA_W, sample_channel_o  out  CH_W: captured sample.
REQ-014 SHALL have ports timeout_o  out  1 (pulse), busy_o  out  1, overrun_cnt_o  out  16 (dropped-tick count).

Function
REQ-015 Tick counter SHALL count 0..SAMPLE_DIV-1 while enable_i=1 and hold at 0 while enable_i=0; tick asserts for one cycle at count SAMPLE_DIV-1, so the first tick occurs SAMPLE_DIV cycles after enable_i rises.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT; busy_o=1 in ISSUE and WAIT.
REQ-017 IDLE + tick: latch channel_i, go to ISSUE; cmd_valid_o SHALL be high in the cycle after the tick.
REQ-018 In ISSUE, cmd_valid_o=cmd_sop_o=cmd_eop_o=1 and cmd_channel_o SHALL hold the latched channel, stable until cmd_ready_i=1; handshake cycle -> WAIT, valid low next cycle.
REQ-019 In WAIT, rsp_valid_i=1 with rsp_channel_i equal to the latched channel SHALL register data and channel and pulse sample_valid_o one cycle later (latency 1), then go to IDLE.
REQ-020 A response with a non-matching channel, or any response outside WAIT, SHALL be ignored.
REQ-021 The timeout counter SHALL clear on leaving IDLE and count in ISSUE and WAIT; at TIMEOUT_CYC it SHALL pulse timeout_o for one cycle, drop cmd_valid_o and return to IDLE.
REQ-022 A matching response in the same cycle as timeout expiry SHALL win: sample delivered, no timeout_o.
REQ-023 A tick while not in IDLE SHALL be dropped and overrun_cnt_o incremented, saturating at 16'hFFFF.
REQ-024 Deasserting enable_i mid-transaction SHALL let the transaction complete (response or timeout); no new ticks follow.
REQ-025 sample_data_o and sample_channel_o SHALL hold their last values between pulses.
REQ-026 When idle, cmd_channel_o SHALL be 0 and the strobes low.

Reset
REQ-027 rst_ni low SHALL immediately force IDLE and zero the tick counter, timeout counter, overrun_cnt_o, and all outputs (valid/strobe/pulse outputs 0, data/channel 0, busy_o 0), including mid-transaction.
REQ-028 After rst_ni rises, the first tick SHALL occur SAMPLE_DIV cycles after enable_i is sampled high.

Structure
REQ-029 Package adc_sched_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT) and the default width constants DATA_W=12 and CH_W=5.
REQ-030 The tick divider SHALL be a sub-module adc_tick_gen (ports clk, rst_ni, enable_i, tick_o; parameter SAMPLE_DIV).

Verification
REQ-031 SAMPLE_DIV=8, ready tied high, response of data 12'hABC on ch 0 three cycles after the command -> cmd_valid_o 1 cycle per tick; sample_valid_o with 12'hABC one cycle after rsp_valid_i.
REQ-032 cmd_ready_i held low for 5 cycles -> cmd_valid_o and cmd_channel_o stable for 6 cycles, single handshake.
REQ-033 TIMEOUT_CYC=16, no response -> timeout_o pulses exactly once, state returns to IDLE, next tick issues a new command.
REQ-034 SAMPLE_DIV=8, response delayed 20 cycles -> overrun_cnt_o=2, single sample delivered.
REQ-035 Response on ch 3 while waiting on ch 0, followed by ch 0 data 12'h123 -> only 12'h123 is output.
REQ-036 rst_ni pulsed low in WAIT -> all outputs 0 within the same cycle, no sample_valid_o from the late response.
